// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the data-cache miss controller.
//   - state_t      : controller FSM encoding (IDLE=0, WB=1, FILL=2, RETRY=3, ERR=4)
//   - TAG_W/IDX_W/WORD_W/MEM_LAT : address split and memory latency
//   - fill_slot_t  : one stage of the fill-return pipe {valid, word}
//   - addr_tag/addr_idx/addr_word : byte-address field extraction
// Address layout: [15:11] tag, [10:3] index, [2:1] word in line, [0] byte.
`ifndef DCACHE_PKG_MACROS
`define DCACHE_PKG_MACROS
`define DC_TAG(a)  a[15:11]
`define DC_IDX(a)  a[10:3]
`define DC_WORD(a) a[2:1]
`endif

package dcache_pkg;

    localparam int TAG_W   = 5;
    localparam int IDX_W   = 8;
    localparam int WORD_W  = 2;
    localparam int MEM_LAT = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        FILL  = 3'd2,
        RETRY = 3'd3,
        ERR   = 3'd4
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] word;
    } fill_slot_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [15:0] a);
        return `DC_TAG(a);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [15:0] a);
        return `DC_IDX(a);
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [15:0] a);
        return `DC_WORD(a);
    endfunction

endpackage

// File: rtl/dcache_fill_pipe.sv
// dcache_fill_pipe: LAT-deep shift register tracking outstanding memory reads.
// A slot pushed in the cycle mem_rd is issued emerges LAT cycles later, exactly
// when the matching word is on mem_data_out, telling the controller which word
// of the line it is.
//   clk, rst_n : clock, asynchronous active-low clear (drops in-flight reads)
//   i_push     : a read is being issued this cycle
//   i_word     : word-in-line of that read
//   o_valid    : mem_data_out carries a returning word this cycle
//   o_word     : word-in-line of the returning data
module dcache_fill_pipe
    import dcache_pkg::*;
#(
    parameter int LAT = MEM_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_word
);

    fill_slot_t r_slot      [LAT];
    fill_slot_t w_slot_next [LAT];

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_slot_next[gi] = {i_push, i_word};
            end else begin : g_body
                assign w_slot_next[gi] = r_slot[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_slot <= w_slot_next;
        end
    end

    assign o_valid = r_slot[LAT-1].valid;
    assign o_word  = r_slot[LAT-1].word;

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: miss-handling FSM for a direct-mapped, write-back, write-allocate
// data cache (4-word lines) in front of a fixed-latency main memory.
//   Processor side : Addr, DataIn, Rd, Wr in; DataOut, Done, Stall, CacheHit,
//                    Err, DCacheReq out.
//   Array side     : c_en/c_comp/c_wr/c_idx/c_word/c_tag_in/c_data_in/c_valid_in
//                    out; c_hit/c_dirty/c_valid/c_tag_out/c_data_out in
//                    (array read data is combinational).
//   Memory side    : mem_rd/mem_wr/mem_addr/mem_data_in out; mem_data_out in,
//                    valid MEM_LAT cycles after mem_rd, no back-pressure.
// Hits complete in the request cycle. Misses write back a dirty victim (WB),
// refill the line (FILL), then repeat the original access (RETRY).
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       Addr,
    input  logic [15:0]       DataIn,
    input  logic              Rd,
    input  logic              Wr,
    output logic [15:0]       DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              Err,
    output logic              DCacheReq,
    output logic              c_en,
    output logic              c_comp,
    output logic              c_wr,
    output logic [IDX_W-1:0]  c_idx,
    output logic [1:0]        c_word,
    output logic [TAG_W-1:0]  c_tag_in,
    output logic [15:0]       c_data_in,
    output logic              c_valid_in,
    input  logic              c_hit,
    input  logic              c_dirty,
    input  logic              c_valid,
    input  logic [TAG_W-1:0]  c_tag_out,
    input  logic [15:0]       c_data_out,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_data_in,
    input  logic [15:0]       mem_data_out
);

    state_t            r_state;
    state_t            w_state_next;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_next;
    logic              r_issue_done;     // all four fill reads issued, waiting on returns
    logic              w_issue_done_next;
    logic              w_fill_push;
    logic              w_pipe_valid;
    logic [WORD_W-1:0] w_pipe_word;
    logic              w_err_req;
    logic              w_req;

    assign w_err_req = (Rd & Wr) | (Addr[0] & (Rd | Wr));
    assign w_req     = Rd ^ Wr;

    dcache_fill_pipe #(
        .LAT (MEM_LAT)
    ) u_fill_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fill_push),
        .i_word  (r_word),
        .o_valid (w_pipe_valid),
        .o_word  (w_pipe_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_issue_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_word       <= w_word_next;
            r_issue_done <= w_issue_done_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_word_next       = r_word;
        w_issue_done_next = r_issue_done;
        w_fill_push       = 1'b0;
        DataOut           = '0;
        Done              = 1'b0;
        Stall             = 1'b0;
        CacheHit          = 1'b0;
        Err               = 1'b0;
        DCacheReq         = 1'b0;
        c_en              = 1'b0;
        c_comp            = 1'b0;
        c_wr              = 1'b0;
        c_idx             = '0;
        c_word            = '0;
        c_tag_in          = '0;
        c_data_in         = '0;
        c_valid_in        = 1'b0;
        mem_rd            = 1'b0;
        mem_wr            = 1'b0;
        mem_addr          = '0;
        mem_data_in       = '0;

        unique case (r_state)
            IDLE: begin
                // rst_n gating keeps every output low while reset is held,
                // even if the processor is still presenting a request.
                if (rst_n && w_err_req) begin
                    w_state_next = ERR;
                end else if (rst_n && w_req) begin
                    DCacheReq  = 1'b1;
                    c_en       = 1'b1;
                    c_comp     = 1'b1;
                    c_wr       = Wr;
                    c_idx      = addr_idx(Addr);
                    c_word     = addr_word(Addr);
                    c_tag_in   = addr_tag(Addr);
                    c_data_in  = DataIn;
                    c_valid_in = 1'b1;
                    w_word_next       = '0;
                    w_issue_done_next = 1'b0;
                    if (c_hit && c_valid) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = Rd ? c_data_out : '0;
                    end else if (c_valid && c_dirty) begin
                        w_state_next = WB;
                    end else begin
                        w_state_next = FILL;
                    end
                end
            end

            WB: begin
                // Victim address comes from the stored tag, not the request.
                Stall       = 1'b1;
                c_en        = 1'b1;
                c_idx       = addr_idx(Addr);
                c_word      = r_word;
                mem_wr      = 1'b1;
                mem_addr    = {c_tag_out, addr_idx(Addr), r_word, 1'b0};
                mem_data_in = c_data_out;
                w_word_next = r_word + 2'd1;
                if (r_word == 2'd3) begin
                    w_state_next = FILL;
                end
            end

            FILL: begin
                Stall = 1'b1;
                if (!r_issue_done) begin
                    mem_rd      = 1'b1;
                    mem_addr    = {Addr[15:3], r_word, 1'b0};
                    w_fill_push = 1'b1;
                    if (r_word == 2'd3) begin
                        w_issue_done_next = 1'b1;
                    end else begin
                        w_word_next = r_word + 2'd1;
                    end
                end
                // Returning words are written in access mode. Only the last one
                // sets valid, so the word-0 write invalidates the line and an
                // interrupted fill leaves it invalid.
                if (w_pipe_valid) begin
                    c_en       = 1'b1;
                    c_wr       = 1'b1;
                    c_idx      = addr_idx(Addr);
                    c_word     = w_pipe_word;
                    c_tag_in   = addr_tag(Addr);
                    c_data_in  = mem_data_out;
                    c_valid_in = (w_pipe_word == 2'd3);
                    if (w_pipe_word == 2'd3) begin
                        w_state_next      = RETRY;
                        w_word_next       = '0;
                        w_issue_done_next = 1'b0;
                    end
                end
            end

            RETRY: begin
                c_en         = 1'b1;
                c_comp       = 1'b1;
                c_wr         = Wr;
                c_idx        = addr_idx(Addr);
                c_word       = addr_word(Addr);
                c_tag_in     = addr_tag(Addr);
                c_data_in    = DataIn;
                c_valid_in   = 1'b1;
                Done         = 1'b1;
                DataOut      = Rd ? c_data_out : '0;
                w_state_next = IDLE;
            end

            ERR: begin
                Err          = 1'b1;
                Done         = 1'b1;
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed and random checks of dcache_ctrl against a
// behavioural tag/data array, a 2-cycle main memory and a reference cache model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Rd, Wr, Done, Stall, CacheHit, Err, DCacheReq;
    logic        c_en, c_comp, c_wr, c_valid_in;
    logic [7:0]  c_idx;
    logic [1:0]  c_word;
    logic [4:0]  c_tag_in;
    logic [15:0] c_data_in;
    logic        c_hit, c_dirty, c_valid;
    logic [4:0]  c_tag_out;
    logic [15:0] c_data_out;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit),
        .Err(Err), .DCacheReq(DCacheReq),
        .c_en(c_en), .c_comp(c_comp), .c_wr(c_wr), .c_idx(c_idx), .c_word(c_word),
        .c_tag_in(c_tag_in), .c_data_in(c_data_in), .c_valid_in(c_valid_in),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid),
        .c_tag_out(c_tag_out), .c_data_out(c_data_out),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    function automatic logic [15:0] pat(input logic [14:0] w);
        return {w, 1'b0} ^ 16'hA5A5;
    endfunction

    // ---------------- tag/data array model (combinational read) ----------------
    logic [4:0]  a_tag   [256]  = '{default: 5'd0};
    logic        a_valid [256]  = '{default: 1'b0};
    logic        a_dirty [256]  = '{default: 1'b0};
    logic [15:0] a_data  [1024] = '{default: 16'h0};

    assign c_valid    = a_valid[c_idx];
    assign c_dirty    = a_dirty[c_idx];
    assign c_tag_out  = a_tag[c_idx];
    assign c_data_out = a_data[{c_idx, c_word}];
    assign c_hit      = c_comp && (a_tag[c_idx] == c_tag_in);

    always @(posedge clk) begin
        if (c_en && c_wr) begin
            if (c_comp) begin
                if (a_valid[c_idx] && a_tag[c_idx] == c_tag_in) begin
                    a_data[{c_idx, c_word}] <= c_data_in;
                    a_dirty[c_idx]          <= 1'b1;
                end
            end else begin
                a_data[{c_idx, c_word}] <= c_data_in;
                a_tag[c_idx]            <= c_tag_in;
                a_valid[c_idx]          <= c_valid_in;
                a_dirty[c_idx]          <= 1'b0;
            end
        end
    end

    // ---------------- main memory model, 2-cycle read latency ----------------
    logic [15:0] mem_val   [32768];
    logic        mem_wrote [32768] = '{default: 1'b0};
    logic [15:0] p1 = 16'h0, p2 = 16'h0;

    function automatic logic [15:0] mem_word(input logic [14:0] w);
        return mem_wrote[w] ? mem_val[w] : pat(w);
    endfunction

    always @(posedge clk) begin
        if (mem_wr) begin
            mem_val[mem_addr[15:1]]   <= mem_data_in;
            mem_wrote[mem_addr[15:1]] <= 1'b1;
        end
        p1 <= mem_rd ? mem_word(mem_addr[15:1]) : 16'h0;
        p2 <= p1;
    end
    assign mem_data_out = p2;

    // ---------------- reference cache model ----------------
    logic [15:0] ref_mem [32768];
    logic [4:0]  m_tag   [256] = '{default: 5'd0};
    logic        m_valid [256] = '{default: 1'b0};
    logic        m_dirty [256] = '{default: 1'b0};
    int          n_expect_req = 0;

    task automatic model_step(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [15:0] d, output int lat, output logic hit,
                              output logic [15:0] data);
        logic [4:0] tg;
        logic [7:0] ix;
        tg = a[15:11];
        ix = a[10:3];
        n_expect_req++;
        hit = m_valid[ix] && (m_tag[ix] == tg);
        if (hit) begin
            lat = 0;
        end else begin
            lat = (m_valid[ix] && m_dirty[ix]) ? 11 : 7;
            m_tag[ix]   = tg;
            m_valid[ix] = 1'b1;
            m_dirty[ix] = 1'b0;
        end
        if (wr) begin
            m_dirty[ix]        = 1'b1;
            ref_mem[a[15:1]]   = d;
        end
        data = rd ? ref_mem[a[15:1]] : 16'h0;
    endtask

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- transaction driver ----------------
    int          x_cyc, x_stall, x_cen, x_req;
    logic [15:0] x_dout;
    logic        x_hit, x_err;
    logic [15:0] rdq[$], wrq[$], wdq[$];
    int          n_req_total   = 0;
    int          n_hit_wo_done = 0;
    int          n_done_stall  = 0;

    task automatic xact(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        x_cyc = -1; x_dout = '0; x_hit = 1'b0; x_err = 1'b0;
        x_stall = 0; x_cen = 0; x_req = 0;
        rdq.delete(); wrq.delete(); wdq.delete();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (DCacheReq) x_req++;
            if (Stall) x_stall++;
            if (c_en) x_cen++;
            if (mem_rd) rdq.push_back(mem_addr);
            if (mem_wr) begin
                wrq.push_back(mem_addr);
                wdq.push_back(mem_data_in);
            end
            if (CacheHit && !Done) n_hit_wo_done++;
            if (Done && Stall) n_done_stall++;
            if (Done) begin
                x_cyc  = c;
                x_dout = DataOut;
                x_hit  = CacheHit;
                x_err  = Err;
            end
            @(posedge clk);
            #1;
            if (x_cyc >= 0) break;
        end
        Rd = 1'b0; Wr = 1'b0;
        n_req_total += x_req;
        chk("done_within_bound", 64'(x_cyc >= 0), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {Done, Stall, CacheHit, Err, DCacheReq, c_en, c_comp, c_wr, c_valid_in,
                  mem_rd, mem_wr, c_idx, c_word, c_tag_in}, 64'd0);
        chk(tag, {DataOut, mem_addr, mem_data_in, c_data_in}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e_lat;
        logic        e_hit;
        logic [15:0] e_data;
        logic [15:0] a;
        logic [15:0] d;
        logic        rd;
        logic [4:0]  tg;

        for (int i = 0; i < 32768; i++) ref_mem[i] = pat(15'(i));

        // ---- reset state ----
        rst_n = 1'b0; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0; DataIn = 16'h0;
        @(negedge clk);
        chk_reset_outputs("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- 1: store 0xBEEF to 0x0010, clean miss ----
        model_step(1'b0, 1'b1, 16'h0010, 16'hBEEF, e_lat, e_hit, e_data);
        xact(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        $display("t1 store 0x0010: done cycle %0d hit %0d", x_cyc, x_hit);
        chk("t1_done_cycle", 64'(x_cyc), 64'd7);
        chk("t1_cachehit", 64'(x_hit), 64'd0);
        chk("t1_stall_cycles", 64'(x_stall), 64'd6);
        chk("t1_req_count", 64'(x_req), 64'd1);
        chk("t1_mem_rd_count", 64'(rdq.size()), 64'd4);
        chk("t1_mem_rd_addrs", {rdq[0], rdq[1], rdq[2], rdq[3]}, 64'h0010_0012_0014_0016);
        chk("t1_mem_wr_count", 64'(wrq.size()), 64'd0);

        // ---- 2: load 0x0010, hit ----
        model_step(1'b1, 1'b0, 16'h0010, 16'h0, e_lat, e_hit, e_data);
        xact(1'b1, 1'b0, 16'h0010, 16'h0);
        $display("t2 load 0x0010: done cycle %0d hit %0d data %h", x_cyc, x_hit, x_dout);
        chk("t2_done_cycle", 64'(x_cyc), 64'd0);
        chk("t2_cachehit", 64'(x_hit), 64'd1);
        chk("t2_dataout", 64'(x_dout), 64'hBEEF);
        chk("t2_mem_strobes", 64'(rdq.size() + wrq.size()), 64'd0);
        chk("t2_stall_cycles", 64'(x_stall), 64'd0);

        // ---- 3: load 0x0810, dirty conflict miss ----
        model_step(1'b1, 1'b0, 16'h0810, 16'h0, e_lat, e_hit, e_data);
        xact(1'b1, 1'b0, 16'h0810, 16'h0);
        $display("t3 load 0x0810: done cycle %0d hit %0d data %h", x_cyc, x_hit, x_dout);
        chk("t3_done_cycle", 64'(x_cyc), 64'd11);
        chk("t3_cachehit", 64'(x_hit), 64'd0);
        chk("t3_stall_cycles", 64'(x_stall), 64'd10);
        chk("t3_mem_wr_count", 64'(wrq.size()), 64'd4);
        chk("t3_mem_wr_addrs", {wrq[0], wrq[1], wrq[2], wrq[3]}, 64'h0010_0012_0014_0016);
        chk("t3_mem_wr_data01", {wdq[0], wdq[1]}, {16'hBEEF, 16'hA5B7});
        chk("t3_mem_rd_addrs", {rdq[0], rdq[1], rdq[2], rdq[3]}, 64'h0810_0812_0814_0816);
        chk("t3_dataout", 64'(x_dout), 64'hADB5);
        chk("t3_memory_word0", 64'(mem_word(15'h0008)), 64'hBEEF);

        model_step(1'b1, 1'b0, 16'h0816, 16'h0, e_lat, e_hit, e_data);
        xact(1'b1, 1'b0, 16'h0816, 16'h0);
        $display("t3b load 0x0816: done cycle %0d hit %0d data %h", x_cyc, x_hit, x_dout);
        chk("t3b_hit", {32'(x_cyc), 16'(x_hit), x_dout}, {32'd0, 16'd1, 16'hADB3});

        // ---- 4: illegal requests ----
        xact(1'b1, 1'b1, 16'h0010, 16'h1234);
        $display("t4a rd&wr: done cycle %0d err %0d", x_cyc, x_err);
        chk("t4a_err_timing", {32'(x_cyc), 16'(x_err), 16'(x_hit)}, {32'd1, 16'd1, 16'd0});
        chk("t4a_no_strobes", 64'(x_cen + rdq.size() + wrq.size() + x_req + x_stall), 64'd0);
        xact(1'b1, 1'b0, 16'h0013, 16'h0);
        $display("t4b odd load 0x0013: done cycle %0d err %0d", x_cyc, x_err);
        chk("t4b_err_timing", {32'(x_cyc), 16'(x_err), 16'(x_hit)}, {32'd1, 16'd1, 16'd0});
        chk("t4b_no_strobes", 64'(x_cen + rdq.size() + wrq.size() + x_req + x_stall), 64'd0);

        // ---- 5: reset during a fill of 0x1010 ----
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h1010; DataIn = 16'h0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("t5_outputs_in_reset");
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("t5_outputs_in_reset_2");
        chk("t5_line_left_invalid", {63'(a_tag[2]), a_valid[2]}, {63'd2, 1'b0});
        Rd = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_valid[2] = 1'b0;
        model_step(1'b1, 1'b0, 16'h1010, 16'h0, e_lat, e_hit, e_data);
        xact(1'b1, 1'b0, 16'h1010, 16'h0);
        $display("t5 load 0x1010 after reset: done cycle %0d hit %0d data %h", x_cyc, x_hit, x_dout);
        chk("t5_done_cycle", 64'(x_cyc), 64'd7);
        chk("t5_cachehit", 64'(x_hit), 64'd0);
        chk("t5_dataout", 64'(x_dout), 64'hB5B5);
        chk("t5_no_writeback", 64'(wrq.size()), 64'd0);

        // ---- 6: random stream against the reference model ----
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       tg = 5'd0;
                1:       tg = 5'd1;
                2:       tg = 5'd2;
                default: tg = 5'd5;
            endcase
            a  = {tg, 8'($urandom_range(2, 3)), 2'($urandom_range(0, 3)), 1'b0};
            rd = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            model_step(rd, !rd, a, d, e_lat, e_hit, e_data);
            xact(rd, !rd, a, d);
            $display("t6[%0d] %s 0x%h: done cycle %0d (exp %0d) hit %0d data %h (exp %h)",
                     t, rd ? "load " : "store", a, x_cyc, e_lat, x_hit, x_dout, e_data);
            chk("t6_latency", 64'(x_cyc), 64'(e_lat));
            chk("t6_cachehit", 64'(x_hit), 64'(e_hit));
            if (rd) chk("t6_dataout", 64'(x_dout), 64'(e_data));
        end

        chk("req_count", 64'(n_req_total), 64'(n_expect_req));
        chk("cachehit_without_done", 64'(n_hit_wo_done), 64'd0);
        chk("done_while_stall", 64'(n_done_stall), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
